// File: rtl/ret_stack_pkg.sv
// Shared constants for the return-address stack and the jump decoder that feeds it.
package ret_stack_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // The decoder derives call/ret from jmp_mode.
  typedef enum logic [1:0] {
    JMP_ABS  = 2'b00,  // absolute jump, also used by CALL
    JMP_BASE = 2'b01,  // base-relative jump
    JMP_RET  = 2'b11   // return through the link register
  } jmp_mode_e;

  // Operation the stack performs at the coming edge.
  typedef enum logic [1:0] {
    OP_IDLE    = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

endpackage

// File: rtl/ret_stack.sv
// Return-address stack: single-cycle push/pop/replace with sticky overflow
// and underflow flags. The top entry is presented combinationally so a RET
// can consume it in the same cycle it is executed.
module ret_stack
  import ret_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       call,
  input  logic                       ret,
  input  logic [WIDTH-1:0]           ret_addr_in,
  output logic [WIDTH-1:0]           lr_addr,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       unf
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [DW-1:0] ONE      = DW'(1);
  localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);

  // Power-up values match the reset values so the stack is usable before the first reset.
  logic [WIDTH-1:0] entries [DEPTH] = '{default: '0};
  logic [DW-1:0]    depth_q = '0;
  logic             ovf_q   = 1'b0;
  logic             unf_q   = 1'b0;

  logic [DW-1:0]    top_cnt;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    push_idx;
  stack_op_e        op;

  // Status decode and index arithmetic; top_idx wraps only when empty, where it is unused.
  always_comb begin
    empty    = (depth_q == '0);
    full     = (depth_q == FULL_CNT);
    top_cnt  = depth_q - ONE;
    top_idx  = top_cnt[AW-1:0];
    push_idx = depth_q[AW-1:0];
    lr_addr  = empty ? '0 : entries[top_idx];
  end

  // Request decode; a simultaneous call/ret on an empty stack degrades to a plain push.
  always_comb begin
    op = OP_IDLE;
    if (call && ret)
      op = empty ? OP_PUSH : OP_REPLACE;
    else if (call)
      op = OP_PUSH;
    else if (ret)
      op = OP_POP;
  end

  // Stack state update; rst wins over any coincident request.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        entries[i] <= '0;
    end else begin
      case (op)
        OP_PUSH: begin
          if (full) begin
            ovf_q <= 1'b1;
          end else begin
            entries[push_idx] <= ret_addr_in;
            depth_q           <= depth_q + ONE;
          end
        end
        OP_POP: begin
          if (empty)
            unf_q <= 1'b1;
          else
            depth_q <= depth_q - ONE;
        end
        OP_REPLACE: entries[top_idx] <= ret_addr_in;
        default: ;
      endcase
    end
  end

  assign depth = depth_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: doc/ret_stack.md
RET_STACK -- requirements
Module: ret_stack

Interface
REQ-001: Parameter WIDTH, 8, instruction-address width in bits; equals the jump unit's address width.
REQ-002: Parameter DEPTH, 8, number of return-address entries; DEPTH >= 2.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst  input  1  reset, synchronous and active-high.
REQ-005: call  input  1  CALL executing this cycle; push ret_addr_in.
REQ-006: ret  input  1  RET executing this cycle; pop top entry.
REQ-007: ret_addr_in  input  WIDTH  return address to push, i.e. the PC of the CALL plus 1, supplied by the core.
REQ-008: lr_addr  output  WIDTH  current top-of-stack return address, fed to the jump unit's link-register input.
REQ-009: depth  output  $clog2(DEPTH+1)  number of valid entries.
REQ-010: empty  output  1  depth == 0.
REQ-011: full  output  1  depth == DEPTH.
REQ-012: ovf  output  1  sticky overflow flag.
REQ-013: unf  output  1  sticky underflow flag.

Function
REQ-014: lr_addr SHALL be combinational from the top entry, entry[depth-1], so a RET consumes it in the same cycle; lr_addr SHALL be 0 when empty.
REQ-015: call=1, ret=0, not full: SHALL write ret_addr_in to entry[depth] and increment depth at the clock edge; new lr_addr is visible in the next cycle.
REQ-016: call=0, ret=1, not empty: SHALL decrement depth at the edge; the popped entry is not cleared.
REQ-017: call=1, ret=1, not empty: SHALL overwrite entry[depth-1] with ret_addr_in and leave depth unchanged (tail-call replace).
REQ-018: call=1, ret=1, empty: SHALL behave as a plain push; unf SHALL NOT be set.
REQ-019: Push when full (call only): SHALL be discarded, with depth and entries unchanged, and ovf set to 1.
REQ-020: Pop when empty (ret only): SHALL be discarded, with depth unchanged, and unf set to 1.
REQ-021: ovf and unf SHALL remain set until rst; no wrap-around of the stack pointer is permitted.
REQ-022: call=0, ret=0: all state SHALL hold.
REQ-023: The block SHALL contain no multi-cycle operation; every request completes at the edge where it is sampled, with no handshake or stall.

Reset
REQ-024: rst=1 at a rising edge SHALL set depth=0, ovf=0, unf=0, and all entries to 0, so that lr_addr=0, empty=1 and full=0 from the next cycle.
REQ-025: rst SHALL take priority over call/ret in the same cycle; a push or pop coincident with rst is lost.
REQ-026: Before the first reset, register initial values SHALL equal the reset values.

Structure
REQ-027: A shared package SHALL hold the default WIDTH/DEPTH constants and the jmp_mode encodings (00 absolute/CALL, 01 base-relative, 11 RET), which the decoder uses to derive call/ret.
REQ-028: No sub-module is required; storage SHALL be an inline DEPTH x WIDTH register array indexed by the depth counter.
REQ-029: The RTL SHALL be synthesizable, with no latches and no asynchronous logic.

Verification
REQ-030: Reset then idle -> depth=0, empty=1, lr_addr=0x00, ovf=0, unf=0.
REQ-031: Push 0x11, 0x22, 0x33 -> lr_addr=0x33, depth=3; pop -> lr_addr=0x22; pop -> 0x11; pop -> empty=1, lr_addr=0x00, unf=0.
REQ-032: Push 8 entries 0x01..0x08 (DEPTH=8) -> full=1; push 0x99 -> depth=8, lr_addr=0x08, ovf=1.
REQ-033: From empty, ret -> unf=1, depth=0; then push 0x44 -> lr_addr=0x44, unf still 1.
REQ-034: Depth=2 with top 0x22; call=ret=1 with ret_addr_in=0x55 -> depth=2, lr_addr=0x55; then pop -> lr_addr=0x11.
REQ-035: Depth=3 with ovf=1; assert rst together with call=1 -> depth=0, ovf=0, lr_addr=0x00 on the next cycle.
